// File: rtl/seller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seller_pkg: coin encodings, coin values, FSM states, coin_value helper       |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
package seller_pkg;

  localparam logic [1:0] c_coin_1   = 2'd0;
  localparam logic [1:0] c_coin_5   = 2'd1;
  localparam logic [1:0] c_coin_10  = 2'd2;
  localparam logic [1:0] c_coin_bad = 2'd3;

  localparam logic [3:0] c_val_1  = 4'd1;
  localparam logic [3:0] c_val_5  = 4'd5;
  localparam logic [3:0] c_val_10 = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CHANGE  = 3'd3,
    ST_REFUND  = 3'd4
  } state_e;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      c_coin_1:  return c_val_1;
      c_coin_5:  return c_val_5;
      c_coin_10: return c_val_10;
      default:   return 4'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seller_change.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seller_change: greedy 10/5/1 coin pick for the given credit                  |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module seller_change
  import seller_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_coin,
  output logic [3:0]          o_value
);

  logic [31:0] w_credit32;

  assign w_credit32 = 32'(i_credit);

  always_comb begin
    if (w_credit32 >= 32'd10) begin
      o_coin = c_coin_10;
    end else if (w_credit32 >= 32'd5) begin
      o_coin = c_coin_5;
    end else begin
      o_coin = c_coin_1;
    end
    o_value = coin_value(o_coin);
  end

endmodule
`default_nettype wire

// File: rtl/ticket_seller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ticket_seller: clocked coin collector, ticket issuer and change/refund payer |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module ticket_seller
  import seller_pkg::*;
#(
  parameter int PRICE_MIN = 2,
  parameter int PRICE_MAX = 10,
  parameter int QTY_MAX   = 3,
  parameter int CREDIT_W  = 8,
  parameter int TIMEOUT   = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_valid,
  input  logic [3:0]          sel_price,
  input  logic [1:0]          sel_qty,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  output logic                coin_reject,
  output logic                sel_err,
  output logic                ticket_valid,
  output logic [3:0]          ticket_price,
  input  logic                ticket_ready,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int         c_tmr_w     = $clog2(TIMEOUT + 1);
  localparam logic [3:0] c_price_min = 4'(PRICE_MIN);
  localparam logic [3:0] c_price_max = 4'(PRICE_MAX);
  localparam logic [1:0] c_qty_max   = 2'(QTY_MAX);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT - 1);

  generate
    if (PRICE_MAX * QTY_MAX >= 2 ** CREDIT_W || CREDIT_W < 4 || PRICE_MAX > 15 ||
        PRICE_MIN < 1 || PRICE_MIN > PRICE_MAX || QTY_MAX < 1 || QTY_MAX > 3 ||
        TIMEOUT < 1) begin : g_param_check
      $error("ticket_seller: illegal parameter combination");
    end
  endgenerate

  state_e                state_q, state_d;
  logic [3:0]            price_q, price_d;
  logic [1:0]            qty_q, qty_d;
  logic [CREDIT_W-1:0]   fare_q, fare_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [c_tmr_w-1:0]    tmr_q, tmr_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  sel_err_q, sel_err_d;
  logic                  ticket_valid_q, change_valid_q, busy_q;
  logic [1:0]            change_coin_q;
  logic [3:0]            change_val_q;

  logic [CREDIT_W:0]     w_sum;
  logic                  w_coin_ok, w_credit, w_hit, w_sel_ok;
  logic [1:0]            w_pick_coin;
  logic [3:0]            w_pick_val;

  // Pick is made on the next credit so the offered coin is registered with it.
  seller_change #(.CREDIT_W(CREDIT_W)) u_change (
    .i_credit (credit_d),
    .o_coin   (w_pick_coin),
    .o_value  (w_pick_val)
  );

  assign w_sum     = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin_type));
  assign w_coin_ok = (coin_type != c_coin_bad) && !w_sum[CREDIT_W];
  assign w_hit     = coin_valid && w_coin_ok && (w_sum[CREDIT_W-1:0] >= fare_q);
  // A cancel only loses the coin when that coin would not complete the fare.
  assign w_credit  = (state_q == ST_COLLECT) && coin_valid && w_coin_ok && (!cancel || w_hit);
  assign w_sel_ok  = (sel_price >= c_price_min) && (sel_price <= c_price_max) &&
                     (sel_qty != 2'd0) && (sel_qty <= c_qty_max);

  always_comb begin
    state_d       = state_q;
    price_d       = price_q;
    qty_d         = qty_q;
    fare_d        = fare_q;
    credit_d      = credit_q;
    tmr_d         = tmr_q;
    coin_reject_d = coin_valid && !w_credit;
    sel_err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          if (w_sel_ok) begin
            price_d = sel_price;
            qty_d   = sel_qty;
            fare_d  = CREDIT_W'(sel_price) * CREDIT_W'(sel_qty);
            tmr_d   = '0;
            state_d = ST_COLLECT;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (w_credit) begin
          credit_d = w_sum[CREDIT_W-1:0];
          tmr_d    = '0;
        end else if (tmr_q != c_tmr_last) begin
          tmr_d = tmr_q + 1'b1;
        end
        if (cancel || (!w_credit && tmr_q == c_tmr_last)) begin
          state_d = (credit_d == '0) ? ST_IDLE : ST_REFUND;
        end else if (w_credit && credit_d >= fare_q) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ticket_valid_q && ticket_ready) begin
          credit_d = credit_q - CREDIT_W'(price_q);
          qty_d    = qty_q - 2'd1;
          if (qty_q == 2'd1) begin
            state_d = (credit_d == '0) ? ST_IDLE : ST_CHANGE;
          end
        end
      end
      ST_CHANGE, ST_REFUND: begin
        if (change_valid_q && change_ready) begin
          credit_d = credit_q - CREDIT_W'(change_val_q);
          if (credit_d == '0) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      price_q        <= '0;
      qty_q          <= '0;
      fare_q         <= '0;
      credit_q       <= '0;
      tmr_q          <= '0;
      coin_reject_q  <= 1'b0;
      sel_err_q      <= 1'b0;
      ticket_valid_q <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= '0;
      change_val_q   <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      price_q        <= price_d;
      qty_q          <= qty_d;
      fare_q         <= fare_d;
      credit_q       <= credit_d;
      tmr_q          <= tmr_d;
      coin_reject_q  <= coin_reject_d;
      sel_err_q      <= sel_err_d;
      ticket_valid_q <= (state_d == ST_ISSUE);
      change_valid_q <= (state_d == ST_CHANGE) || (state_d == ST_REFUND);
      change_coin_q  <= w_pick_coin;
      change_val_q   <= w_pick_val;
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign coin_reject  = coin_reject_q;
  assign sel_err      = sel_err_q;
  assign ticket_valid = ticket_valid_q;
  assign ticket_price = price_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign credit       = credit_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire
